// File: rtl/hilo_unit.sv
// hilo_unit
// HI/LO register file for the EX stage of the toy CPU.
// MTHI/MTLO, multiply and multiply-accumulate results commit in one cycle.
// Divides run through a restoring divider that produces one quotient bit
// per cycle, for WIDTH cycles in total.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op_valid_i, op_i  operation strobe and 4-bit opcode
//   a_i, b_i          operands (dividend / divisor for divides)
//   cancel_i          flush: aborts a running divide, drops the presented op
//   hi_o, lo_o        HI and LO registers
//   busy_o            divider running; the producer must hold its op
//   done_o            one-cycle pulse after a divide commits
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_MTHI  = 4'd1;
  localparam logic [3:0] OP_MTLO  = 4'd2;
  localparam logic [3:0] OP_MULT  = 4'd3;
  localparam logic [3:0] OP_MULTU = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_DIV   = 4'd9;
  localparam logic [3:0] OP_DIVU  = 4'd10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_DIV  = 1'b1
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_negQ;
  logic               r_negR;

  logic               w_accept;
  logic               w_isSigned;
  logic [2*WIDTH-1:0] w_extA;
  logic [2*WIDTH-1:0] w_extB;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_acc;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [WIDTH-1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic [WIDTH-1:0]   w_quoFinal;
  logic [WIDTH-1:0]   w_remFinal;
  logic               w_lastIter;

  assign w_accept = op_valid_i & (r_state == S_IDLE) & ~cancel_i;

  assign w_isSigned = (op_i == OP_MULT) | (op_i == OP_MADD) |
                      (op_i == OP_MSUB) | (op_i == OP_DIV);

  // Extending both operands to 2*WIDTH and multiplying modulo 2^(2*WIDTH)
  // gives the exact two's-complement product for signed ops.
  assign w_extA = w_isSigned ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
  assign w_extB = w_isSigned ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
  assign w_prod = w_extA * w_extB;
  assign w_acc  = {r_hi, r_lo};

  // Magnitudes are WIDTH bits wide.
  // The most-negative value maps to 2^(WIDTH-1), which is still correct
  // when the value is read as unsigned.
  assign w_absA = (w_isSigned && a_i[WIDTH-1]) ? (-a_i) : a_i;
  assign w_absB = (w_isSigned && b_i[WIDTH-1]) ? (-b_i) : b_i;

  // Restoring step: the dividend shifts out of r_quo, MSB first.
  // Quotient bits shift into r_quo from the bottom.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
  assign w_fits    = ~w_trial[WIDTH];
  assign w_remNext = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_quoNext = {r_quo[WIDTH-2:0], w_fits};

  assign w_quoFinal = r_negQ ? (-w_quoNext) : w_quoNext;
  assign w_remFinal = r_negR ? (-w_remNext) : w_remNext;
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  // Main state register.
  // In IDLE it commits single-cycle ops or launches a divide.
  // In DIV it runs one restoring iteration per cycle and commits on the
  // last one, unless cancel_i aborts the divide first.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op_i)
              OP_MTHI: r_hi <= a_i;
              OP_MTLO: r_lo <= a_i;
              OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod;
              OP_MADD, OP_MADDU: {r_hi, r_lo} <= w_acc + w_prod;
              OP_MSUB, OP_MSUBU: {r_hi, r_lo} <= w_acc - w_prod;
              OP_DIV, OP_DIVU: begin
                if (b_i == '0) begin
                  r_hi <= a_i;
                  r_lo <= '1;
                end else begin
                  r_rem   <= '0;
                  r_quo   <= w_absA;
                  r_dvs   <= w_absB;
                  r_negQ  <= w_isSigned & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                  r_negR  <= w_isSigned & a_i[WIDTH-1];
                  r_cnt   <= '0;
                  r_state <= S_DIV;
                end
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          if (cancel_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            if (w_lastIter) begin
              r_hi    <= w_remFinal;
              r_lo    <= w_quoFinal;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi_o   = r_hi;
  assign lo_o   = r_lo;
  assign busy_o = (r_state == S_DIV);
  assign done_o = r_done;

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit
// Scoreboard bench for hilo_unit with WIDTH=32.
// The stimulus side keeps an arithmetic model of HI/LO and queues the
// expected outcome of each issued op.
// A monitor process pops those entries and compares them against the DUT,
// sampling on the falling clock edge.
module tb_hilo_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          opValid;
  logic [3:0]    op;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cancel;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;

  hilo_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid_i (opValid),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .cancel_i   (cancel),
    .hi_o       (hi),
    .lo_o       (lo),
    .busy_o     (busy),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // isDiv entries describe a divide.
  // cycles is the expected busy length, expDone says whether it commits,
  // and oldHi/oldLo are the values that must hold while busy is high.
  typedef struct packed {
    logic        isDiv;
    logic [7:0]  cycles;
    logic        expDone;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic [31:0] oldHi;
    logic [31:0] oldLo;
  } exp_t;

  exp_t         sbQ[$];
  int           nVectors = 0;
  int           nMiscompares = 0;
  logic [31:0]  mHi = '0;
  logic [31:0]  mLo = '0;

  // Record one comparison and report it if it misses.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    nVectors++;
    if (act !== req) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference behaviour, written directly from the arithmetic definitions.
  task automatic modelOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] pS;
    logic [63:0] pU;
    logic [63:0] acc;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    pS  = 64'(sx * sy);
    pU  = {32'b0, x} * {32'b0, y};
    acc = {mHi, mLo};
    case (o)
      4'd1: mHi = x;
      4'd2: mLo = x;
      4'd3: {mHi, mLo} = pS;
      4'd4: {mHi, mLo} = pU;
      4'd5: {mHi, mLo} = acc + pS;
      4'd6: {mHi, mLo} = acc + pU;
      4'd7: {mHi, mLo} = acc - pS;
      4'd8: {mHi, mLo} = acc - pU;
      4'd9, 4'd10: begin
        if (y == 0) begin
          mHi = x;
          mLo = 32'hFFFFFFFF;
        end else if (o == 4'd9) begin
          q   = sx / sy;
          r   = sx % sy;
          mLo = q[31:0];
          mHi = r[31:0];
        end else begin
          mLo = x / y;
          mHi = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Drive one cycle of inputs.
  // Returns just after the rising edge that samples them.
  task automatic applyStimulus(input logic v, input logic [3:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic c, input logic r);
    opValid = v;
    op      = o;
    a       = x;
    b       = y;
    cancel  = c;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  // Random ops presented while the divider is busy.
  // The DUT must ignore all of them.
  task automatic junkCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic pushImm();
    exp_t e;
    e = '{isDiv: 1'b0, cycles: 8'd0, expDone: 1'b0, expHi: mHi, expLo: mLo, oldHi: mHi, oldLo: mLo};
    sbQ.push_back(e);
  endtask

  // Issue an op in IDLE.
  // A real divide is followed by W held cycles, so the next issue lands in
  // the done cycle.
  task automatic issueOp(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    exp_t        e;
    logic [31:0] oH;
    logic [31:0] oL;
    logic        longDiv;
    oH      = mHi;
    oL      = mLo;
    longDiv = (o == 4'd9 || o == 4'd10) && (y != 0);
    applyStimulus(1'b1, o, x, y, c, 1'b0);
    if (c) begin
      pushImm();
    end else begin
      modelOp(o, x, y);
      if (longDiv) begin
        e = '{isDiv: 1'b1, cycles: 8'(W), expDone: 1'b1, expHi: mHi, expLo: mLo, oldHi: oH, oldLo: oL};
        sbQ.push_back(e);
        junkCycles(W);
      end else begin
        pushImm();
      end
    end
  endtask

  // Start a divide, then abort it at edge k with cancel or with reset.
  task automatic abortDiv(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int k, input logic useReset);
    exp_t e;
    applyStimulus(1'b1, o, x, y, 1'b0, 1'b0);
    e = '{isDiv: 1'b1, cycles: 8'(k), expDone: 1'b0,
          expHi: useReset ? 32'h0 : mHi, expLo: useReset ? 32'h0 : mLo, oldHi: mHi, oldLo: mLo};
    sbQ.push_back(e);
    junkCycles(k - 1);
    applyStimulus(1'b1, 4'd1, $urandom, $urandom, ~useReset, useReset);
    if (useReset) begin
      mHi = '0;
      mLo = '0;
    end
  endtask

  // Monitor: pops one expectation per presented result and compares it.
  initial begin : monitor
    exp_t e;
    int   cnt;
    logic holdBad;
    forever begin
      @(negedge clk);
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        if (!e.isDiv) begin
          checkOutput("hi", 64'(hi), 64'(e.expHi));
          checkOutput("lo", 64'(lo), 64'(e.expLo));
          checkOutput("busy", 64'(busy), 64'd0);
          checkOutput("done", 64'(done), 64'd0);
        end else begin
          cnt     = 0;
          holdBad = 1'b0;
          while (busy === 1'b1 && cnt < W + 8) begin
            cnt++;
            if (hi !== e.oldHi || lo !== e.oldLo || done !== 1'b0) holdBad = 1'b1;
            @(negedge clk);
          end
          checkOutput("div_busy_cycles", 64'(cnt), 64'(e.cycles));
          checkOutput("div_hold", 64'(holdBad), 64'd0);
          checkOutput("div_done", 64'(done), 64'(e.expDone));
          checkOutput("div_hi", 64'(hi), 64'(e.expHi));
          checkOutput("div_lo", 64'(lo), 64'(e.expLo));
        end
      end
    end
  end

  // Watchdog: stops a run that would otherwise hang.
  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus: directed cases first, then randomized ops.
  initial begin : stimulus
    logic [31:0] x;
    logic [31:0] y;
    int          waitCnt;
    opValid = 1'b0;
    op      = '0;
    a       = '0;
    b       = '0;
    cancel  = 1'b0;
    rst     = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 4'd3, 32'h5, 32'h7, 1'b0, 1'b1);
    pushImm();

    issueOp(4'd1, 32'h12345678, 32'h0, 1'b0);
    issueOp(4'd2, 32'h9ABCDEF0, 32'h0, 1'b0);
    issueOp(4'd3, 32'hFFFFFFFD, 32'd5, 1'b0);
    issueOp(4'd6, 32'h10, 32'h1, 1'b0);
    issueOp(4'd9, 32'hFFFFFFF9, 32'd2, 1'b0);
    issueOp(4'd10, 32'hDEADBEEF, 32'h0, 1'b0);
    issueOp(4'd9, 32'h80000000, 32'hFFFFFFFF, 1'b0);

    abortDiv(4'd10, 32'd100, 32'd7, 10, 1'b0);
    issueOp(4'd2, 32'hCAFEF00D, 32'h0, 1'b0);
    abortDiv(4'd10, 32'd100, 32'd7, W, 1'b0);
    issueOp(4'd1, 32'h0BADBEEF, 32'h0, 1'b0);
    abortDiv(4'd10, 32'd100, 32'd7, 5, 1'b1);
    issueOp(4'd0, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0:       x = 32'h80000000;
        1:       x = 32'($urandom_range(0, 20)) - 32'd10;
        default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       y = 32'h0;
        1:       y = 32'hFFFFFFFF;
        2:       y = 32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      issueOp(4'($urandom_range(0, 15)), x, y, 1'($urandom_range(0, 9) == 0));
    end

    opValid = 1'b0;
    waitCnt = 0;
    while (sbQ.size() > 0 && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    repeat (2) @(negedge clk);
    if (sbQ.size() != 0) checkOutput("drain", 64'(sbQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
